// File: rtl/riscv_hwloop_seq.sv
// riscv_hwloop_seq
//
// Hardware-loop sequencer. While idle it watches the fetch PC for the end
// address of any active loop (counter != 0). The lowest-index hit wins, since
// that is the innermost loop. With two or more iterations left it requests a
// redirect to the loop start and then a counter decrement. On the last
// iteration (counter == 1) it falls through and only requests the decrement.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   hwlp_start_addr_i   N_REGS x 32 loop start addresses (flattened, reg k at [k*32 +: 32])
//   hwlp_end_addr_i     N_REGS x 32 loop end addresses (PC of last body instruction)
//   hwlp_counter_i      N_REGS x 32 current loop counters
//   pc_i, pc_valid_i    PC presented by fetch and its valid flag
//   fetch_ready_i       fetch accepts the redirect this cycle
//   id_valid_i          tracked instruction retires from ID this cycle
//   flush_i             pipeline flush; abandons any sequence in progress
//   hwlp_jump_o         redirect request, high only while waiting on fetch
//   hwlp_target_o       redirect target, holds its last value when not jumping
//   hwlp_dec_cnt_o      one-hot decrement request, only while waiting on ID
//   hwlp_loop_id_o      index of the loop being sequenced
//   busy_o              sequencer not idle; fetch holds pc_i while high
module riscv_hwloop_seq #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REGS*32-1:0]   hwlp_start_addr_i,
  input  logic [N_REGS*32-1:0]   hwlp_end_addr_i,
  input  logic [N_REGS*32-1:0]   hwlp_counter_i,
  input  logic [31:0]            pc_i,
  input  logic                   pc_valid_i,
  input  logic                   fetch_ready_i,
  input  logic                   id_valid_i,
  input  logic                   flush_i,
  output logic                   hwlp_jump_o,
  output logic [31:0]            hwlp_target_o,
  output logic [N_REGS-1:0]      hwlp_dec_cnt_o,
  output logic [N_REG_BITS-1:0]  hwlp_loop_id_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    JUMP_REQ = 2'd1,
    DEC_PEND = 2'd2
  } state_t;

  state_t                 state;
  logic [N_REGS-1:0]      pending;

  logic                   match;
  logic [N_REG_BITS-1:0]  match_id;
  logic [N_REGS-1:0]      match_oh;
  logic [31:0]            match_start;
  logic [31:0]            match_cnt;

  // Stage 0: end-address compare across all loops. Scanning from the top
  // index down lets the lowest matching index overwrite any higher one.
  always_comb begin
    match       = 1'b0;
    match_id    = '0;
    match_oh    = '0;
    match_start = '0;
    match_cnt   = '0;
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if (hwlp_end_addr_i[k*32 +: 32] == pc_i && hwlp_counter_i[k*32 +: 32] != 32'd0) begin
        match       = 1'b1;
        match_id    = N_REG_BITS'(k);
        match_oh    = '0;
        match_oh[k] = 1'b1;
        match_start = hwlp_start_addr_i[k*32 +: 32];
        match_cnt   = hwlp_counter_i[k*32 +: 32];
      end
    end
  end

  // Stage 1: sequencer state and registered outputs. Flush shares the reset
  // path so it always beats fetch_ready_i / id_valid_i in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state          <= IDLE;
      pending        <= '0;
      hwlp_jump_o    <= 1'b0;
      hwlp_target_o  <= '0;
      hwlp_dec_cnt_o <= '0;
      hwlp_loop_id_o <= '0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_valid_i && match) begin
            pending        <= match_oh;
            hwlp_loop_id_o <= match_id;
            busy_o         <= 1'b1;
            if (match_cnt > 32'd1) begin
              hwlp_target_o <= match_start;
              hwlp_jump_o   <= 1'b1;
              state         <= JUMP_REQ;
            end else begin
              // Last iteration: no redirect, straight to the decrement.
              hwlp_dec_cnt_o <= match_oh;
              state          <= DEC_PEND;
            end
          end
        end
        JUMP_REQ: begin
          if (fetch_ready_i) begin
            hwlp_jump_o    <= 1'b0;
            hwlp_dec_cnt_o <= pending;
            state          <= DEC_PEND;
          end
        end
        DEC_PEND: begin
          if (id_valid_i) begin
            pending        <= '0;
            hwlp_dec_cnt_o <= '0;
            busy_o         <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          pending        <= '0;
          hwlp_jump_o    <= 1'b0;
          hwlp_dec_cnt_o <= '0;
          busy_o         <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_hwloop_seq.sv
// tb_riscv_hwloop_seq
//
// Directed scenario tasks followed by randomized transactions. The random
// phase predicts each transaction from its rules: which loop matches, how
// many cycles the redirect and decrement phases last, and where a flush cuts
// the sequence short.
module tb_riscv_hwloop_seq;

  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N*32-1:0]  start_a = '0;
  logic [N*32-1:0]  end_a   = '0;
  logic [N*32-1:0]  cnt_a   = '0;
  logic [31:0]      pc = '0;
  logic             pc_valid = 1'b0;
  logic             fetch_ready = 1'b0;
  logic             id_valid = 1'b0;
  logic             flush = 1'b0;
  logic             hwlp_jump;
  logic [31:0]      hwlp_target;
  logic [N-1:0]     hwlp_dec_cnt;
  logic             hwlp_loop_id;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_hwloop_seq #(.N_REGS(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .hwlp_start_addr_i (start_a),
    .hwlp_end_addr_i   (end_a),
    .hwlp_counter_i    (cnt_a),
    .pc_i              (pc),
    .pc_valid_i        (pc_valid),
    .fetch_ready_i     (fetch_ready),
    .id_valid_i        (id_valid),
    .flush_i           (flush),
    .hwlp_jump_o       (hwlp_jump),
    .hwlp_target_o     (hwlp_target),
    .hwlp_dec_cnt_o    (hwlp_dec_cnt),
    .hwlp_loop_id_o    (hwlp_loop_id),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {jump, target, dec_cnt, loop_id, busy}.
  wire [36:0] obs = {hwlp_jump, hwlp_target, hwlp_dec_cnt, hwlp_loop_id, busy};

  function automatic logic [36:0] pk(logic j, logic [31:0] t, logic [1:0] d, logic id, logic b);
    return {j, t, d, id, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_reg(int k, logic [31:0] s, logic [31:0] e, logic [31:0] c);
    start_a[k*32 +: 32] = s;
    end_a[k*32 +: 32]   = e;
    cnt_a[k*32 +: 32]   = c;
  endtask

  task automatic test_reset();
    logic [36:0] exp_v;
    rst = 1'b1;
    step();
    step();
    smp();
    exp_v = pk(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset: got %h expected %h", obs, exp_v); end
    rst = 1'b0;
    step();
    smp();
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL post_reset_idle: got %h expected %h", obs, exp_v); end
    step();
  endtask

  task automatic test_jump();
    logic [36:0] exp_v;
    set_reg(0, 32'h0F0, 32'h100, 32'd3);
    set_reg(1, 32'h400, 32'h500, 32'd5);
    pc = 32'h100; pc_valid = 1'b1; fetch_ready = 1'b1;
    step();
    smp();
    exp_v = pk(1'b1, 32'h0F0, 2'b00, 1'b0, 1'b1);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s1_jump: got %h expected %h", obs, exp_v); end
    step();
    fetch_ready = 1'b0;
    smp();
    exp_v = pk(1'b0, 32'h0F0, 2'b01, 1'b0, 1'b1);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s1_dec: got %h expected %h", obs, exp_v); end
    step();
    smp();
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s1_dec_hold: got %h expected %h", obs, exp_v); end
    id_valid = 1'b1;
    step();
    id_valid = 1'b0; pc_valid = 1'b0;
    smp();
    exp_v = pk(1'b0, 32'h0F0, 2'b00, 1'b0, 1'b0);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s1_idle_after: got %h expected %h", obs, exp_v); end
    step();
  endtask

  task automatic test_fallthrough();
    logic [36:0] exp_v;
    set_reg(0, 32'h0E0, 32'h100, 32'd1);
    pc = 32'h100; pc_valid = 1'b1;
    step();
    smp();
    exp_v = pk(1'b0, 32'h0F0, 2'b01, 1'b0, 1'b1);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s2_dec_no_jump: got %h expected %h", obs, exp_v); end
    id_valid = 1'b1;
    step();
    id_valid = 1'b0; pc_valid = 1'b0;
    smp();
    exp_v = pk(1'b0, 32'h0F0, 2'b00, 1'b0, 1'b0);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s2_idle_after: got %h expected %h", obs, exp_v); end
    step();
  endtask

  task automatic test_priority();
    logic [36:0] exp_v;
    logic [31:0] tgt;
    logic        pid;
    logic [1:0]  oh;
    for (int p = 0; p < 2; p++) begin
      pid = (p == 1);
      tgt = pid ? 32'h180 : 32'h1C0;
      oh  = pid ? 2'b10 : 2'b01;
      set_reg(0, 32'h1C0, 32'h200, pid ? 32'd0 : 32'd4);
      set_reg(1, 32'h180, 32'h200, 32'd4);
      pc = 32'h200; pc_valid = 1'b1; fetch_ready = 1'b1;
      step();
      pc_valid = 1'b0;
      smp();
      exp_v = pk(1'b1, tgt, 2'b00, pid, 1'b1);
      n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL s3_jump[%0d]: got %h expected %h", p, obs, exp_v); end
      step();
      fetch_ready = 1'b0;
      smp();
      exp_v = pk(1'b0, tgt, oh, pid, 1'b1);
      n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL s3_dec[%0d]: got %h expected %h", p, obs, exp_v); end
      id_valid = 1'b1;
      step();
      id_valid = 1'b0;
      smp();
      exp_v = pk(1'b0, tgt, 2'b00, pid, 1'b0);
      n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL s3_idle[%0d]: got %h expected %h", p, obs, exp_v); end
      step();
    end
  endtask

  task automatic test_stall();
    logic [36:0] exp_v;
    set_reg(0, 32'h2A0, 32'h300, 32'd2);
    set_reg(1, 32'h320, 32'h340, 32'd7);
    pc = 32'h300; pc_valid = 1'b1; fetch_ready = 1'b0;
    step();
    pc = 32'h340;
    exp_v = pk(1'b1, 32'h2A0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      smp();
      n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL s4_stall[%0d]: got %h expected %h", i, obs, exp_v); end
      step();
    end
    fetch_ready = 1'b1;
    smp();
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s4_release: got %h expected %h", obs, exp_v); end
    step();
    fetch_ready = 1'b0;
    smp();
    exp_v = pk(1'b0, 32'h2A0, 2'b01, 1'b0, 1'b1);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s4_dec: got %h expected %h", obs, exp_v); end
    id_valid = 1'b1;
    step();
    id_valid = 1'b0; pc_valid = 1'b0;
    smp();
    exp_v = pk(1'b0, 32'h2A0, 2'b00, 1'b0, 1'b0);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s4_exit_ignores_pc: got %h expected %h", obs, exp_v); end
    step();
  endtask

  task automatic test_flush();
    logic [36:0] exp_v;
    logic [36:0] zero_v;
    zero_v = pk(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    set_reg(0, 32'h0F0, 32'h100, 32'd1);
    pc = 32'h100; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    smp();
    exp_v = pk(1'b0, 32'h2A0, 2'b01, 1'b0, 1'b1);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s5_dec: got %h expected %h", obs, exp_v); end
    flush = 1'b1; id_valid = 1'b1;
    step();
    flush = 1'b0; id_valid = 1'b0;
    smp();
    n_chk++;
    if (obs !== zero_v) begin n_fail++; $display("FAIL s5_flush_dec: got %h expected %h", obs, zero_v); end
    step();
    set_reg(0, 32'h0F0, 32'h100, 32'd3);
    set_reg(1, 32'h480, 32'h500, 32'd2);
    pc = 32'h500; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    smp();
    exp_v = pk(1'b1, 32'h480, 2'b00, 1'b1, 1'b1);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s5_jump: got %h expected %h", obs, exp_v); end
    flush = 1'b1; fetch_ready = 1'b1;
    step();
    flush = 1'b0; fetch_ready = 1'b0;
    smp();
    n_chk++;
    if (obs !== zero_v) begin n_fail++; $display("FAIL s5_flush_jump: got %h expected %h", obs, zero_v); end
    step();
    pc = 32'h100; pc_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; pc_valid = 1'b0;
    smp();
    n_chk++;
    if (obs !== zero_v) begin n_fail++; $display("FAIL s5_flush_match: got %h expected %h", obs, zero_v); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [36:0] exp_v;
    logic [36:0] zero_v;
    zero_v = pk(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    set_reg(0, 32'h0F0, 32'h100, 32'd3);
    pc = 32'h100; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    smp();
    exp_v = pk(1'b1, 32'h0F0, 2'b00, 1'b0, 1'b1);
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL s6_jump: got %h expected %h", obs, exp_v); end
    rst = 1'b1; fetch_ready = 1'b1;
    step();
    rst = 1'b0; fetch_ready = 1'b0;
    smp();
    n_chk++;
    if (obs !== zero_v) begin n_fail++; $display("FAIL s6_reset_mid: got %h expected %h", obs, zero_v); end
    step();
    smp();
    n_chk++;
    if (obs !== zero_v) begin n_fail++; $display("FAIL s6_no_pulse: got %h expected %h", obs, zero_v); end
    set_reg(0, 32'h0F0, 32'h100, 32'd0);
    pc = 32'h100; pc_valid = 1'b1;
    step();
    smp();
    n_chk++;
    if (obs !== zero_v) begin n_fail++; $display("FAIL s6_cnt0_no_action: got %h expected %h", obs, zero_v); end
    step();
    smp();
    n_chk++;
    if (obs !== zero_v) begin n_fail++; $display("FAIL s6_cnt0_still_idle: got %h expected %h", obs, zero_v); end
    pc_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] pool [3];
    logic [31:0] c;
    logic [31:0] cnt_k;
    logic [31:0] m_target;
    logic        m_id;
    logic        done;
    logic        in_jump;
    logic [1:0]  oh;
    logic [36:0] exp_v;
    int          mk, jl, total, fl;
    pool[0] = 32'h1000; pool[1] = 32'h2000; pool[2] = 32'h3000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_target = '0;
    m_id     = 1'b0;
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 4))
          0:       c = 32'd0;
          1:       c = 32'd1;
          2:       c = 32'd2;
          3:       c = 32'hFFFF_FFFF;
          default: c = $urandom_range(3, 1000);
        endcase
        set_reg(k, $urandom & 32'hFFFF_FFFC, pool[$urandom_range(0, 2)], c);
      end
      pc = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : pool[$urandom_range(0, 2)];
      mk = -1;
      for (int k = 0; k < N; k++)
        if (mk < 0 && end_a[k*32 +: 32] == pc && cnt_a[k*32 +: 32] != 32'd0) mk = k;
      jl = 0; total = 0; oh = 2'b00;
      if (mk >= 0) begin
        cnt_k = cnt_a[mk*32 +: 32];
        oh    = 2'b01 << mk;
        jl    = (cnt_k >= 32'd2) ? int'($urandom_range(1, 4)) : 0;
        total = jl + int'($urandom_range(1, 4));
      end
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total)) : -1;
      pc_valid    = 1'b1;
      flush       = (fl == 0);
      fetch_ready = 1'($urandom_range(0, 1));
      id_valid    = 1'($urandom_range(0, 1));
      smp();
      exp_v = pk(1'b0, m_target, 2'b00, m_id, 1'b0);
      n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rnd_idle[%0d]: got %h expected %h", t, obs, exp_v); end
      step();
      done = 1'b0;
      if (fl == 0) begin
        m_target = '0; m_id = 1'b0; done = 1'b1;
      end else if (mk >= 0) begin
        m_id = (mk == 1);
        if (jl > 0) m_target = start_a[mk*32 +: 32];
      end
      for (int j = 1; j <= total + 1; j++) begin
        if (done || j > total) begin
          pc_valid = 1'b0; flush = 1'b0; fetch_ready = 1'b0; id_valid = 1'b0;
          smp();
          exp_v = pk(1'b0, m_target, 2'b00, m_id, 1'b0);
          n_chk++;
          if (obs !== exp_v) begin n_fail++; $display("FAIL rnd_end[%0d]: got %h expected %h", t, obs, exp_v); end
          break;
        end
        in_jump     = (j <= jl);
        pc          = pool[$urandom_range(0, 2)];
        pc_valid    = 1'b1;
        flush       = (fl == j);
        fetch_ready = in_jump ? (j == jl) : 1'($urandom_range(0, 1));
        id_valid    = in_jump ? 1'($urandom_range(0, 1)) : (j == total);
        smp();
        exp_v = pk(in_jump, m_target, in_jump ? 2'b00 : oh, m_id, 1'b1);
        n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rnd_busy[%0d.%0d]: got %h expected %h", t, j, obs, exp_v); end
        step();
        if (fl == j) begin
          m_target = '0; m_id = 1'b0; done = 1'b1;
        end
      end
      step();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_jump();
    test_fallthrough();
    test_priority();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/riscv_hwloop_seq.md
RISCV_HWLOOP_SEQ -- requirements
Module: riscv_hwloop_seq

Interface
REQ-001 SHALL have parameter N_REGS, default 2: number of hardware-loop register sets sequenced.
REQ-002 SHALL have parameter N_REG_BITS, default $clog2(N_REGS): loop-index width.
REQ-003 SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 hwlp_start_addr_i  input  N_REGS x 32  loop start addresses from the hwloop register file.
REQ-007 hwlp_end_addr_i  input  N_REGS x 32  loop end addresses (PC of last loop-body instruction).
REQ-008 hwlp_counter_i  input  N_REGS x 32  current loop counters.
REQ-009 pc_i  input  32  PC of the instruction currently presented by fetch.
REQ-010 pc_valid_i  input  1  pc_i is valid this cycle.
REQ-011 fetch_ready_i  input  1  fetch accepts the redirect this cycle.
REQ-012 id_valid_i  input  1  the tracked instruction retires from ID this cycle.
REQ-013 flush_i  input  1  pipeline flush (branch, exception, debug).
REQ-014 hwlp_jump_o  output  1  redirect request to fetch.
REQ-015 hwlp_target_o  output  32  redirect target address.
REQ-016 hwlp_dec_cnt_o  output  N_REGS  one-hot decrement request to the register file.
REQ-017 hwlp_loop_id_o  output  N_REG_BITS  index of the loop being sequenced.
REQ-018 busy_o  output  1  high whenever the FSM is not IDLE; fetch holds pc_i while busy_o is high.

Function
REQ-019 SHALL implement a 3-state FSM: IDLE, JUMP_REQ, DEC_PEND.
REQ-020 SHALL flag a match in IDLE only: pc_valid_i=1, pc_i==hwlp_end_addr_i[k], and hwlp_counter_i[k]!=0.
REQ-021 SHALL resolve multiple matching loops by lowest index (innermost loop), with exactly one index selected.
REQ-022 SHALL, on a match with counter>=2, register target=hwlp_start_addr_i[k], loop_id=k and pending=one-hot(k), then enter JUMP_REQ.
REQ-023 SHALL, on a match with counter==1, register loop_id and pending but not the target, and enter DEC_PEND directly (fall through, no jump).
REQ-024 SHALL use unsigned 32-bit compares for counter tests, so 0xFFFFFFFF counts as >=2.
REQ-025 JUMP_REQ: SHALL drive hwlp_jump_o=1 with a stable hwlp_target_o until fetch_ready_i=1, then enter DEC_PEND on the next edge.
REQ-026 hwlp_jump_o SHALL be 0 in every state other than JUMP_REQ; a jump therefore appears one cycle after the match cycle.
REQ-027 DEC_PEND: SHALL drive hwlp_dec_cnt_o=pending; on id_valid_i=1 SHALL clear pending and return to IDLE.
REQ-028 hwlp_dec_cnt_o SHALL be all-zero outside DEC_PEND and never have more than one bit set.
REQ-029 SHALL ignore pc_i matches in JUMP_REQ and DEC_PEND, including in the cycle DEC_PEND exits.
REQ-030 SHALL, on flush_i=1 in any state, go to IDLE next cycle, clear pending, target and loop_id, and issue no decrement; flush_i has priority over fetch_ready_i and id_valid_i in the same cycle.
REQ-031 SHALL not evaluate a match in a cycle where flush_i=1.
REQ-032 hwlp_target_o SHALL hold its last registered value outside JUMP_REQ, and be 0 after reset or flush.

Reset
REQ-033 SHALL, while rst=1 at a clock edge, force state=IDLE, hwlp_jump_o=0, hwlp_target_o=0, hwlp_dec_cnt_o=0, hwlp_loop_id_o=0 and busy_o=0.
REQ-034 SHALL abandon a redirect or decrement in progress when reset is asserted mid-operation, with no output pulse after the reset edge.

Verification
REQ-035 Scenario 1: end[0]=0x100, start[0]=0x0F0, cnt[0]=3; pc_i=0x100 valid; fetch_ready_i=1 -> next cycle jump_o=1 with target=0x0F0; following cycle dec_cnt_o=2'b01 until id_valid_i.
REQ-036 Scenario 2: cnt[0]=1 at match -> jump_o never asserts; dec_cnt_o=2'b01 one cycle after the match; IDLE after id_valid_i.
REQ-037 Scenario 3: end[0]=end[1]=0x200, cnt[0]=cnt[1]=4 -> loop_id_o=0 and dec_cnt_o=2'b01 only; cnt[0]=0 -> loop 1 is selected instead.
REQ-038 Scenario 4: fetch_ready_i=0 for 3 cycles in JUMP_REQ -> jump_o=1 and target stable for all 3 cycles; a pc_i change to another end address during the stall is ignored.
REQ-039 Scenario 5: flush_i=1 in DEC_PEND together with id_valid_i=1 -> dec_cnt_o=0 next cycle, IDLE, busy_o=0.
REQ-040 Scenario 6: rst=1 in JUMP_REQ -> all outputs 0 after the edge; cnt[0]=0 with pc_i=end[0] -> no action.
